// File: rtl/rand_arbiter.sv
// rtl/rand_arbiter.sv - round-robin arbiter sharing one seeded LFSR core among requesters
module rand_arbiter #(
  parameter int          N_REQ        = 4,
  parameter int          WARMUP       = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'd1907200704
) (
  input  logic             clk,
  input  logic             RESET_SIM,
  input  logic [N_REQ-1:0] req,
  input  logic             reseed,
  input  logic [31:0]      seed_in,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      rand_out,
  output logic             rand_valid,
  output logic             busy,
  output logic             rng_ld_seed,
  output logic [31:0]      rng_seed,
  output logic             rng_step,
  input  logic [31:0]      rng_value
);

  localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CW = (WARMUP > 2) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {SEED, WARM, READY} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    pick_next;
  logic             found;
  logic [CW-1:0]    warm_cnt;
  logic [N_REQ-1:0] eligible;

  // Last cycle's grant is masked: that requester is dropping req this cycle.
  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    pick     = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && eligible[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign pick_next   = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
  assign busy        = (state != READY);
  assign rng_ld_seed = (state == SEED);
  // The core advances on the same edge that captures its value, so no value repeats.
  assign rng_step    = !reseed && ((state == WARM) || ((state == READY) && found));

  always_ff @(posedge clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      state      <= SEED;
      rng_seed   <= SEED_DEFAULT;
      ptr        <= '0;
      warm_cnt   <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_out   <= '0;
    end else if (reseed) begin
      rng_seed   <= (seed_in == 32'd0) ? SEED_DEFAULT : seed_in;
      state      <= SEED;
      warm_cnt   <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
    end else begin
      case (state)
        SEED: begin
          gnt        <= '0;
          rand_valid <= 1'b0;
          warm_cnt   <= '0;
          state      <= (WARMUP > 0) ? WARM : READY;
        end
        WARM: begin
          gnt        <= '0;
          rand_valid <= 1'b0;
          if (warm_cnt == CW'(WARMUP - 1)) begin
            state <= READY;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        READY: begin
          if (found) begin
            gnt        <= N_REQ'(1) << pick;
            rand_out   <= rng_value;
            rand_valid <= 1'b1;
            ptr        <= pick_next;
          end else begin
            gnt        <= '0;
            rand_valid <= 1'b0;
          end
        end
        default: state <= SEED;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// tb/tb_rand_arbiter.sv - self-checking bench for rand_arbiter with an LFSR core and behavioural model
module tb_rand_arbiter;

  localparam int          N_REQ  = 4;
  localparam int          WARMUP = 8;
  localparam logic [31:0] DEF    = 32'd1907200704;

  logic              clk = 1'b0;
  logic              RESET_SIM = 1'b1;
  logic [N_REQ-1:0]  req = '0;
  logic              reseed = 1'b0;
  logic [31:0]       seed_in = '0;
  logic [N_REQ-1:0]  gnt;
  logic [31:0]       rand_out;
  logic              rand_valid;
  logic              busy;
  logic              rng_ld_seed;
  logic [31:0]       rng_seed;
  logic              rng_step;
  logic [31:0]       rng_value;

  rand_arbiter #(.N_REQ(N_REQ), .WARMUP(WARMUP), .SEED_DEFAULT(DEF)) dut (
    .clk(clk), .RESET_SIM(RESET_SIM), .req(req), .reseed(reseed), .seed_in(seed_in),
    .gnt(gnt), .rand_out(rand_out), .rand_valid(rand_valid), .busy(busy),
    .rng_ld_seed(rng_ld_seed), .rng_seed(rng_seed), .rng_step(rng_step), .rng_value(rng_value)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic logic [31:0] lfsr_at(input logic [31:0] s, input int n);
    logic [31:0] v = s;
    for (int i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

  function automatic int first_from(input logic [N_REQ-1:0] elig, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (elig[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  // RNG core: loads on rng_ld_seed, advances on rng_step
  logic [31:0] core = '0;
  always @(posedge clk) begin
    if (rng_ld_seed) core <= rng_seed;
    else if (rng_step) core <= lfsr_next(core);
  end
  assign rng_value = core;

  // Model: m_left = busy cycles remaining (WARMUP+1 means seed-load cycle),
  // m_steps = position in the seed's LFSR sequence of the next value to hand out.
  int          m_left = WARMUP + 1;
  int          m_ptr = 0;
  int          m_steps = 0;
  logic [31:0] m_seed = DEF;
  logic [31:0] m_out = '0;
  logic [N_REQ-1:0] m_gnt = '0;
  logic        m_valid = 1'b0;

  always @(posedge clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      m_left = WARMUP + 1; m_ptr = 0; m_steps = 0; m_seed = DEF;
      m_out = '0; m_gnt = '0; m_valid = 1'b0;
    end else if (reseed) begin
      m_seed = (seed_in == 32'd0) ? DEF : seed_in;
      m_left = WARMUP + 1; m_gnt = '0; m_valid = 1'b0;
    end else if (m_left > 0) begin
      if (m_left == WARMUP + 1) m_steps = 0;
      else m_steps++;
      m_left--; m_gnt = '0; m_valid = 1'b0;
    end else begin
      int j;
      j = first_from(req & ~m_gnt, m_ptr);
      if (j >= 0) begin
        m_gnt   = N_REQ'(1 << j);
        m_out   = lfsr_at(m_seed, m_steps);
        m_steps++;
        m_valid = 1'b1;
        m_ptr   = (j + 1) % N_REQ;
      end else begin
        m_gnt = '0; m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_step;
      exp_step = !reseed && !RESET_SIM &&
                 ((m_left >= 1 && m_left <= WARMUP) ||
                  (m_left == 0 && first_from(req & ~m_gnt, m_ptr) >= 0));
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("rand_valid", 32'(rand_valid), 32'(m_valid));
      check("rand_out", rand_out, m_out);
      check("busy", 32'(busy), 32'(m_left != 0));
      check("rng_ld_seed", 32'(rng_ld_seed), 32'(m_left == WARMUP + 1));
      check("rng_seed", rng_seed, m_seed);
      check("rng_step", 32'(rng_step), 32'(exp_step));
    end
  end

  logic [N_REQ-1:0] auto_rr = '0;
  logic [N_REQ-1:0] rearm = '0;
  int n_step, n_ld, n_gnt;
  logic s_busy;

  // One clock: sample at negedge, then requester behaviour just after the edge.
  task automatic cycle();
    @(negedge clk);
    n_step += int'(rng_step);
    n_ld   += int'(rng_ld_seed);
    n_gnt  += int'(gnt != '0);
    s_busy = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        req[i] = 1'b0; rearm[i] = auto_rr[i];
      end else if (rearm[i]) begin
        req[i] = 1'b1; rearm[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (busy && k < 40) begin
      cycle(); k++;
    end
    check("ready_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [31:0] first_val;
    logic [31:0] vals [5];
    logic [N_REQ-1:0] exp_rot [5];
    int first_ready, dups;

    check("lfsr_pin1", lfsr_at(32'h2, 2), 32'h80200003);
    check("lfsr_pin2", lfsr_at(32'h80200003, 1), 32'hC0300002);

    repeat (3) cycle();
    cmp_en = 1'b1;
    cycle();
    check("t1_reset_seed", rng_seed, 32'd1907200704);
    check("t1_reset_gnt", 32'(gnt), 32'd0);

    // Test 1: bring-up
    RESET_SIM = 1'b0;
    n_step = 0; n_ld = 0; n_gnt = 0; first_ready = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (!s_busy && first_ready == 0) first_ready = c;
    end
    check("t1_ld_cycles", 32'(n_ld), 32'd1);
    check("t1_step_cycles", 32'(n_step), 32'd8);
    check("t1_ready_cycle", 32'(first_ready), 32'd10);
    check("t1_no_gnt", 32'(n_gnt), 32'd0);

    // Test 2: single request
    req = 4'b0100; n_step = 0;
    cycle();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_value", rand_out, lfsr_at(DEF, 8));
    first_val = rand_out;
    cycle();
    check("t2_step_once", 32'(n_step), 32'd1);

    req = 4'b1000;
    cycle(); cycle();

    // Test 3: all requesters, rotation from pointer 0
    exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
    exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;
    auto_rr = 4'b1111; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_rot", 32'(gnt), 32'(exp_rot[k]));
      check("t3_value", rand_out, lfsr_at(DEF, 10 + k));
      vals[k] = rand_out;
    end
    auto_rr = '0; rearm = '0; req = '0;
    dups = 0;
    for (int a = 0; a < 5; a++)
      for (int b = a + 1; b < 5; b++)
        if (vals[a] == vals[b]) dups++;
    check("t3_distinct", 32'(dups), 32'd0);
    cycle();

    // Test 4: reseed with zero seed while requests pending (pointer is 1)
    req = 4'b0011; reseed = 1'b1; seed_in = 32'd0; n_gnt = 0;
    cycle();
    reseed = 1'b0;
    check("t4_seed", rng_seed, 32'd1907200704);
    wait_ready();
    check("t4_no_gnt_busy", 32'(n_gnt), 32'd0);
    cycle();
    check("t4_gnt_ptr", 32'(gnt), 32'h2);
    check("t4_repeat_seq", rand_out, first_val);
    cycle();
    check("t4_gnt_next", 32'(gnt), 32'h1);
    check("t4_value2", rand_out, lfsr_at(DEF, 9));
    cycle();

    // Test 5: reseed during warm-up cycle 3
    reseed = 1'b1; seed_in = 32'h12345678;
    cycle();
    reseed = 1'b0;
    cycle(); cycle(); cycle();
    reseed = 1'b1; seed_in = 32'hDEADBEEF; n_step = 0;
    cycle();
    reseed = 1'b0;
    check("t5_seed", rng_seed, 32'hDEADBEEF);
    wait_ready();
    check("t5_warm_steps", 32'(n_step), 32'd8);
    req = 4'b1000;
    cycle();
    check("t5_gnt", 32'(gnt), 32'h8);
    check("t5_value", rand_out, lfsr_at(32'hDEADBEEF, 8));
    cycle();

    // Test 6: reset during a grant cycle
    req = 4'b0010;
    cycle();
    check("t6_gnt_before", 32'(gnt), 32'h2);
    #2 RESET_SIM = 1'b1;
    #1;
    check("t6_async_gnt", 32'(gnt), 32'd0);
    check("t6_async_valid", 32'(rand_valid), 32'd0);
    check("t6_async_out", rand_out, 32'd0);
    cycle(); cycle();
    RESET_SIM = 1'b0;
    wait_ready();
    req = 4'b1010;
    cycle();
    check("t6_lowest_first", 32'(gnt), 32'h2);
    check("t6_value", rand_out, lfsr_at(DEF, 8));
    cycle();
    check("t6_second", 32'(gnt), 32'h8);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
